// File: rtl/apb_pkg.sv
// Shared APB types, protection bit constants and bridge FSM state encoding.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

  typedef logic [APB_ADDR_W-1:0] addr_t;
  typedef logic [APB_DATA_W-1:0] data_t;
  typedef logic [APB_STRB_W-1:0] strb_t;
  typedef logic [2:0]            prot_t;

  localparam prot_t PROT_PRIV   = 3'b001;
  localparam prot_t PROT_NONSEC = 3'b010;
  localparam prot_t PROT_INSTR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB master bridge with optional access timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Abort is decided in the last allowed ACCESS cycle, i.e. when TIMEOUT_CYCLES-1 waits are already counted.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  apb_state_e              state_q;
  logic [CNT_W-1:0]        wcnt_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [2:0]              pprot_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [STRB_W-1:0]       pstrb_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      paddr_q     <= '0;
      pprot_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            paddr_q  <= req_addr_i;
            pprot_q  <= req_prot_i;
            pwrite_q <= req_write_i;
            pwdata_q <= req_wdata_i;
            pstrb_q  <= req_write_i ? req_strb_i : '0;
            psel_q   <= 1'b1;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          wcnt_q    <= '0;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_i) begin
            rsp_rdata_q <= pwrite_q ? '0 : prdata_i;
            rsp_err_q   <= pslverr_i;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if ((TIMEOUT_CYCLES > 0) && (wcnt_q == CNT_LAST)) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (TIMEOUT_CYCLES > 0) begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign paddr_o     = paddr_q;
  assign pprot_o     = pprot_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge (TIMEOUT_CYCLES = 8).
module tb_apb_master_bridge;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;

  logic        pready_man, slave_en;
  logic [31:0] prdata_man;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  apb_master_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_write_i(req_write),
    .req_wdata_i(req_wdata),
    .req_strb_i (req_strb),
    .req_prot_i (req_prot),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .paddr_o    (paddr),
    .pprot_o    (pprot),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .pwdata_o   (pwdata),
    .pstrb_o    (pstrb),
    .pready_i   (pready),
    .prdata_i   (prdata),
    .pslverr_i  (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
  endfunction

  // Zero-wait memory completer used for the back-to-back run.
  assign pready = slave_en | pready_man;
  assign prdata = slave_en ? mem[paddr[5:2]] : prdata_man;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (slave_en && psel && penable && pwrite) begin
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) mem[paddr[5:2]][8*b +: 8] <= pwdata[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshakes one request; returns in SETUP cycle with fields scrambled.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p, output int hs_cyc);
    int n;
    n = 0;
    req_addr = a; req_write = w; req_wdata = d; req_strb = s; req_prot = p;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin tick(); n++; end
    if (!req_ready) check("issue_ready_timeout", 0, 1);
    hs_cyc = cyc;
    tick();
    req_valid = 1'b0;
    req_addr = ~a; req_write = ~w; req_wdata = ~d; req_strb = ~s; req_prot = ~p;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    if (!rsp_valid) check("rsp_valid_timeout", 0, 1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, prev;
    int idx;
    logic        w;
    logic [31:0] d, exp_rd;
    logic [3:0]  s;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; rsp_ready = 1'b0; pready_man = 1'b0; pslverr = 1'b0;
    prdata_man = '0; slave_en = 1'b0;
    tick(); tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_paddr", paddr, 0);
    check("rst_pstrb", pstrb, 0);
    rst_n = 1'b1;
    tick();

    // Zero-wait write
    issue(32'h1000_0040, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, hs);
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_paddr", paddr, 32'h1000_0040);
    check("wr_pwdata", pwdata, 32'hDEAD_BEEF);
    check("wr_pstrb", pstrb, 4'hF);
    check("wr_pprot", pprot, 3'b010);
    check("wr_pwrite", pwrite, 1);
    tick();
    check("wr_access_penable", penable, 1);
    check("wr_access_paddr", paddr, 32'h1000_0040);
    pready_man = 1'b1; prdata_man = 32'hFFFF_FFFF;
    tick();
    pready_man = 1'b0;
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_lat", cyc - hs, 3);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_rsp_psel", psel, 0);
    check("wr_rsp_req_ready", req_ready, 0);
    consume();
    check("wr_idle_rsp_valid", rsp_valid, 0);
    check("wr_idle_req_ready", req_ready, 1);

    // Read with 3 wait states
    issue(32'h2000_0004, 1'b0, 32'h5555_5555, 4'hF, 3'b001, hs);
    check("rd_setup_pstrb", pstrb, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rd_wait_penable", penable, 1);
      check("rd_wait_paddr", paddr, 32'h2000_0004);
      check("rd_wait_pstrb", pstrb, 0);
      check("rd_wait_rsp_valid", rsp_valid, 0);
      tick();
    end
    check("rd_acc4_paddr", paddr, 32'h2000_0004);
    pready_man = 1'b1; prdata_man = 32'h1234_5678;
    tick();
    pready_man = 1'b0; prdata_man = 32'h0;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_lat", cyc - hs, 6);
    check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("rd_rsp_err", rsp_err, 0);
    consume();

    // Slave error, response held under back-pressure
    issue(32'h3000_0008, 1'b0, 32'h0, 4'h0, 3'b000, hs);
    tick();
    pready_man = 1'b1; pslverr = 1'b1; prdata_man = 32'hCAFE_0000;
    tick();
    pready_man = 1'b0; pslverr = 1'b0; prdata_man = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      check("err_hold_valid", rsp_valid, 1);
      check("err_hold_err", rsp_err, 1);
      check("err_hold_rdata", rsp_rdata, 32'hCAFE_0000);
      check("err_hold_req_ready", req_ready, 0);
      tick();
    end
    consume();
    check("err_done_req_ready", req_ready, 1);

    // Timeout with pready stuck low
    issue(32'h4000_0000, 1'b0, 32'h0, 4'h0, 3'b000, hs);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("to_access_psel", psel, 1);
      check("to_access_rsp_valid", rsp_valid, 0);
      tick();
    end
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel", psel, 0);
    check("to_penable", penable, 0);
    consume();

    // pready on the 8th ACCESS cycle wins over the timeout
    issue(32'h4000_0004, 1'b0, 32'h0, 4'h0, 3'b000, hs);
    tick();
    for (int i = 0; i < 7; i++) begin
      check("to8_access_psel", psel, 1);
      tick();
    end
    pready_man = 1'b1; prdata_man = 32'hA5A5_5A5A;
    tick();
    pready_man = 1'b0;
    check("to8_rsp_valid", rsp_valid, 1);
    check("to8_rsp_err", rsp_err, 0);
    check("to8_rsp_rdata", rsp_rdata, 32'hA5A5_5A5A);
    consume();

    // Asynchronous reset during an ACCESS wait state
    issue(32'h5000_0010, 1'b1, 32'h0BAD_F00D, 4'h3, 3'b000, hs);
    tick(); tick();
    check("rstm_pre_penable", penable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstm_psel", psel, 0);
    check("rstm_penable", penable, 0);
    check("rstm_rsp_valid", rsp_valid, 0);
    check("rstm_req_ready", req_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rstm_after_req_ready", req_ready, 1);
    check("rstm_after_rsp_valid", rsp_valid, 0);
    issue(32'h5000_0020, 1'b0, 32'h0, 4'h0, 3'b000, hs);
    tick();
    pready_man = 1'b1; prdata_man = 32'h7777_0001;
    tick();
    pready_man = 1'b0;
    check("rstm_fresh_valid", rsp_valid, 1);
    check("rstm_fresh_rdata", rsp_rdata, 32'h7777_0001);
    check("rstm_fresh_err", rsp_err, 0);
    consume();

    // Back-to-back against a zero-wait memory
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    slave_en = 1'b1;
    rsp_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      idx = int'($urandom_range(0, 15));
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      s   = 4'($urandom_range(1, 15));
      exp_rd = w ? 32'h0 : ref_mem[idx];
      if (w)
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      issue(32'h6000_0000 | 32'(idx << 2), w, d, s, 3'b000, hs);
      wait_rsp();
      check("b2b_rdata", rsp_rdata, exp_rd);
      check("b2b_err", rsp_err, 0);
      if (i > 0) check("b2b_interval", hs - prev, 4);
      prev = hs;
      tick();
    end
    rsp_ready = 1'b0;
    slave_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      issue(32'h6000_0000 | 32'(i << 2), 1'b0, 32'h0, 4'h0, 3'b000, hs);
      slave_en = 1'b1;
      wait_rsp();
      check("b2b_final_mem", rsp_rdata, ref_mem[i]);
      consume();
      slave_en = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a single-outstanding valid/ready request/response port into an APB master: SETUP phase, then ACCESS phase, then response.
- Sits between an internal initiator (core debug port, DMA config port) and an APB bus or demux.
- Drives the Master-side signal set (paddr, pprot, psel, penable, pwrite, pwdata, pstrb) and consumes pready, prdata and pslverr.
- Has an optional access timeout so a dead completer cannot hang the initiator.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width; must be a multiple of 8
TIMEOUT_CYCLES, 0, maximum ACCESS cycles without pready before abort; 0 disables the timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when high together with req_valid_i
req_addr_i  in  ADDR_WIDTH  request address
req_write_i  in  1  1 = write, 0 = read
req_wdata_i  in  DATA_WIDTH  write data
req_strb_i  in  DATA_WIDTH/8  write byte strobes
req_prot_i  in  3  protection attributes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err_o  out  1  pslverr or timeout
paddr_o  out  ADDR_WIDTH  APB address
pprot_o  out  3  APB protection
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_WIDTH  APB write data
pstrb_o  out  DATA_WIDTH/8  APB strobes
pready_i  in  1  completer ready
prdata_i  in  DATA_WIDTH  completer read data
pslverr_i  in  1  completer error

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: every registered output is 0, including psel_o, penable_o, rsp_valid_o and all data/address outputs. The FSM resets to IDLE. req_ready_o is 1 out of reset.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, register addr, prot, write and wdata into the APB outputs.
  - pstrb_o = req_strb_i for writes and all-zero for reads.
  - Go to SETUP.
- SETUP (exactly one cycle): psel_o = 1, penable_o = 0. Go to ACCESS.
- ACCESS:
  - psel_o = 1, penable_o = 1.
  - Stay in ACCESS while pready_i = 0.
  - On pready_i = 1: capture rsp_rdata_o (prdata_i for reads, 0 for writes) and rsp_err_o = pslverr_i. Next cycle psel_o = 0, penable_o = 0. Go to RESP.
- Timeout:
  - A wait counter is cleared on entry to ACCESS and increments on each ACCESS cycle with pready_i = 0.
  - When TIMEOUT_CYCLES > 0 and the counter reaches TIMEOUT_CYCLES, abort: rsp_err_o = 1, rsp_rdata_o = 0, drop psel_o/penable_o, go to RESP.
  - pready_i high in the same cycle the limit is reached takes priority over the timeout: the response is normal.
  - Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
- RESP:
  - rsp_valid_o = 1; rsp_rdata_o and rsp_err_o are held stable until rsp_ready_i.
  - On rsp_ready_i, go to IDLE.
  - req_ready_o = 0, so no overlap between consecutive transfers.
- Stability: paddr_o, pprot_o, pwrite_o, pwdata_o and pstrb_o are stable from SETUP through the last ACCESS cycle and hold their last value while psel_o = 0.
- Latency: request handshake in cycle N gives SETUP in N+1 and ACCESS in N+2. With zero wait states, rsp_valid_o is high in N+3. Minimum issue interval is 4 cycles.
- Back-pressure: no combinational path from pready_i or rsp_ready_i to any APB output. req_ready_o is decoded from state only.
- Reset mid-transfer: psel_o, penable_o and rsp_valid_o drop immediately (asynchronous). The in-flight request is discarded and no response is produced.
- Request fields are sampled only on the accepting handshake. Changes to the request fields after acceptance are ignored.

Decomposition:
- Shared package apb_pkg: addr_t/data_t/strb_t typedefs sized from ADDR_WIDTH/DATA_WIDTH defaults; prot_t (3 bits); pprot bit constants (PRIV, NONSEC, INSTR); APB state enum.
- No sub-module needed. The timeout counter is small enough to stay inline.

Test Plan:
- Zero-wait write: req addr=0x1000_0040, wdata=0xDEAD_BEEF, strb=0xF, prot=3'b010 → SETUP then ACCESS on pins, pstrb=0xF; rsp_valid in cycle N+3 with err=0, rdata=0.
- Read with 3 wait states: prdata=0x1234_5678 presented with pready on the 4th ACCESS cycle → rsp_rdata=0x1234_5678 at N+6; pstrb=0 throughout; paddr stable across all ACCESS cycles.
- Slave error: read with pslverr=1 alongside pready → rsp_err=1; response held 5 cycles under rsp_ready=0 with values unchanged; req_ready stays 0 until the response is consumed.
- Timeout: TIMEOUT_CYCLES=8, pready tied 0 → abort after 8 ACCESS cycles, psel drops, rsp_err=1, rdata=0. Repeat with pready arriving on cycle 8 → normal response.
- Reset mid-ACCESS: assert rst_ni low during a wait state → psel/penable/rsp_valid are 0 without a clock edge; after release, req_ready=1 and a fresh read completes correctly.
- Back-to-back: 16 random reads/writes with rsp_ready held high → each issues exactly 4 cycles apart, with order and data matching a reference memory model.
